conveng_feeder: RTL and testbench
=================================

Name: conveng_feeder

Overview:
- Upstream sequencer for conveng. It accepts row slices of NPIX pixels from a line source over a valid/ready handshake.
- It drives conveng's data bus and its rowShift/colShift strobes:
  - a LOAD phase of ROWS row shifts;
  - a SWEEP phase of COLS column shifts;
  - single-row ADVANCE steps between sweeps, repeated until the whole image height has been consumed.
- It also produces out_valid, aligned to conveng's result pipeline, so downstream logic knows when data_o/res are meaningful.

Parameters:
- ROWS, 16, row shifts needed to fill the conveng window.
- COLS, 18, column shifts per sweep.
- PIX_W, 8, bits per pixel.
- NPIX, 22, pixels per row slice.
- TAG_W, 4, sideband tag bits appended at the LSBs of data.
- PIPE_LAT, 4, cycles from a colShift strobe to the corresponding valid conveng output.
- H_W, 12, width of the image-height field.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  one-cycle pulse; begins a frame when idle
- img_rows  input  H_W  image height in rows; sampled on accepted start
- in_data  input  NPIX*PIX_W  row slice pixels
- in_tag  input  TAG_W  row slice tag
- in_valid  input  1  row slice available
- in_ready  output  1  feeder accepts a slice this cycle
- data  output  NPIX*PIX_W+TAG_W  {in_data,in_tag} to conveng
- rowShift  output  1  row shift strobe to conveng
- colShift  output  1  column shift strobe to conveng
- out_valid  output  1  conveng output valid
- busy  output  1  frame in progress
- done  output  1  one-cycle end-of-frame pulse

Behaviour:
- Reset values: data=0, rowShift=0, colShift=0, out_valid=0, busy=0, done=0, all counters 0, state IDLE. Reset mid-frame aborts the frame and clears the PIPE_LAT delay line; no done pulse is issued.
- All outputs are registered except in_ready. in_ready = (state==LOAD || state==ADVANCE), combinational from state only.
- Handshake: a slice is accepted at an edge where in_valid && in_ready.
  - On that edge: data <= {in_data,in_tag} and rowShift <= 1.
  - rowShift is 1 only in the cycle following each accept and 0 otherwise.
  - data holds its last value when no slice is accepted.
- Stalls: in_valid low in LOAD/ADVANCE simply waits with no strobe. There is no timeout.
- IDLE:
  - start with img_rows >= ROWS: latch img_rows, clear counters, busy <= 1, go to LOAD.
  - start with img_rows < ROWS: ignored; stay IDLE, no done.
  - start while busy: ignored.
- LOAD: count accepts. On the ROWS-th accept go to SWEEP; rows_in = ROWS.
- SWEEP:
  - colShift <= 1 for exactly COLS consecutive cycles, starting the cycle after entry.
  - After the COLS-th strobe: if rows_in < img_rows go to ADVANCE, else go to DRAIN.
  - colShift is never 1 in the same cycle as rowShift.
- ADVANCE: on one accept, rows_in <= rows_in+1 and go to SWEEP.
- DRAIN: wait PIPE_LAT cycles, then pulse done=1 for one cycle, busy <= 0, go to IDLE.
- Sweeps per frame = img_rows - ROWS + 1. Total rowShift pulses = img_rows. Total colShift pulses = COLS*(img_rows-ROWS+1).
- out_valid is colShift delayed by PIPE_LAT cycles through a shift register. The last out_valid occurs before or in the same cycle as done.
- Boundary cases:
  - img_rows == ROWS: a single sweep, with no ADVANCE.
  - img_rows = 2^H_W-1: rows_in must not overflow; rows_in is H_W bits wide.
- Counter widths: LOAD count ceil(log2(ROWS+1)), column count ceil(log2(COLS+1)).

Test Plan:
- Reset held low 3 cycles, then released with no start → all outputs 0, in_ready=0, busy=0 indefinitely.
- img_rows=16, start, in_valid held 1 with in_data bytes = row index, in_tag=4'hF:
  - 16 rowShift pulses on consecutive cycles;
  - last data = {22{8'h0F},4'hF};
  - then 18 consecutive colShift pulses;
  - out_valid 18 cycles starting 4 cycles after the first colShift;
  - done 4 cycles after the last colShift; busy falls with done.
- img_rows=17, second-phase slice bytes 8'hEA:
  - after the first sweep, exactly one rowShift with data={22{8'hEA},4'hF};
  - then a second 18-cycle sweep;
  - totals: rowShift=17, colShift=36, out_valid=36, done=1.
- Randomly toggle in_valid (≈50% low) with img_rows=18 → strobe counts unchanged (18 rowShift, 54 colShift); rowShift only follows an accept; rowShift&&colShift never observed.
- start with img_rows=15, and start pulsed mid-frame → both ignored; the first produces no busy or done; the second leaves the frame's counts unaffected.
- reset asserted during the 5th colShift of a sweep → outputs 0 asynchronously; out_valid never reasserts from the aborted frame; a new start afterwards completes normally.

Source files
------------

// File: rtl/conveng_feeder.sv
// conveng_feeder: upstream sequencer for the conveng window engine.
//
// Takes row slices of NPIX pixels from a line source over a valid/ready
// handshake. For each frame it runs three kinds of steps:
//   LOAD    - ROWS row shifts, which fill the conveng window
//   SWEEP   - COLS column shifts, one per cycle
//   ADVANCE - a single row shift between two sweeps
// ADVANCE and SWEEP repeat until img_rows rows have been consumed.
// DRAIN then waits for the result pipeline to empty, and done is pulsed.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      one-cycle pulse; starts a frame when idle
//   img_rows_i   image height in rows, sampled when start is accepted
//   in_data_i    row slice pixels
//   in_tag_i     row slice sideband tag
//   in_valid_i   row slice available
//   in_ready_o   slice accepted this cycle when in_valid_i is also high
//                (combinational from state)
//   data_o       {in_data, in_tag} of the last accepted slice
//   rowShift_o   row shift strobe, in the cycle after each accept
//   colShift_o   column shift strobe during a sweep
//   out_valid_o  colShift_o delayed by PIPE_LAT cycles
//   busy_o       frame in progress
//   done_o       one-cycle end-of-frame pulse
module conveng_feeder #(
  parameter int ROWS     = 16,
  parameter int COLS     = 18,
  parameter int PIX_W    = 8,
  parameter int NPIX     = 22,
  parameter int TAG_W    = 4,
  parameter int PIPE_LAT = 4,
  parameter int H_W      = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [H_W-1:0]              img_rows_i,
  input  logic [NPIX*PIX_W-1:0]       in_data_i,
  input  logic [TAG_W-1:0]            in_tag_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  output logic [NPIX*PIX_W+TAG_W-1:0] data_o,
  output logic                        rowShift_o,
  output logic                        colShift_o,
  output logic                        out_valid_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int DATA_W = NPIX*PIX_W + TAG_W;
  localparam int LD_W   = $clog2(ROWS + 1);
  localparam int COL_W  = $clog2(COLS + 1);
  localparam int DR_W   = $clog2(PIPE_LAT + 1);

  localparam logic [H_W-1:0]   ROWS_H   = H_W'(ROWS);
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(ROWS - 1);
  localparam logic [LD_W-1:0]  LD_FULL  = LD_W'(ROWS);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [DR_W-1:0]  DR_LAST  = DR_W'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SWEEP   = 3'd2,
    ADVANCE = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               row_shift_q, row_shift_d;
  logic               col_shift_q, col_shift_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [H_W-1:0]     img_rows_q, img_rows_d;
  logic [H_W-1:0]     rows_in_q, rows_in_d;
  logic [LD_W-1:0]    load_cnt_q, load_cnt_d;
  logic [COL_W-1:0]   col_cnt_q, col_cnt_d;
  logic [DR_W-1:0]    drain_cnt_q, drain_cnt_d;
  logic [PIPE_LAT-1:0] pipe_q;
  logic               accept;

  assign in_ready_o = (state_q == LOAD) || (state_q == ADVANCE);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    row_shift_d = 1'b0;
    col_shift_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    img_rows_d  = img_rows_q;
    rows_in_d   = rows_in_q;
    load_cnt_d  = load_cnt_q;
    col_cnt_d   = col_cnt_q;
    drain_cnt_d = drain_cnt_q;

    // in_ready_o only rises in LOAD/ADVANCE, so every accept is one row shift.
    if (accept) begin
      data_d      = {in_data_i, in_tag_i};
      row_shift_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A start that asks for fewer rows than one window is dropped.
        if (start_i && (img_rows_i >= ROWS_H)) begin
          img_rows_d  = img_rows_i;
          rows_in_d   = '0;
          load_cnt_d  = '0;
          col_cnt_d   = '0;
          drain_cnt_d = '0;
          busy_d      = 1'b1;
          state_d     = LOAD;
        end
      end

      LOAD: begin
        if (accept) begin
          if (load_cnt_q == LD_LAST) begin
            load_cnt_d = LD_FULL;
            rows_in_d  = ROWS_H;
            col_cnt_d  = '0;
            state_d    = SWEEP;
          end else begin
            load_cnt_d = load_cnt_q + LD_W'(1);
          end
        end
      end

      SWEEP: begin
        // The first strobe is registered at the edge after entry. It is
        // therefore seen one cycle after the final rowShift and never
        // overlaps it.
        col_shift_d = 1'b1;
        if (col_cnt_q == COL_LAST) begin
          col_cnt_d   = '0;
          drain_cnt_d = '0;
          state_d     = (rows_in_q < img_rows_q) ? ADVANCE : DRAIN;
        end else begin
          col_cnt_d = col_cnt_q + COL_W'(1);
        end
      end

      ADVANCE: begin
        // rows_in_q < img_rows_q holds here, so the increment cannot wrap.
        if (accept) begin
          rows_in_d = rows_in_q + H_W'(1);
          state_d   = SWEEP;
        end
      end

      DRAIN: begin
        // DRAIN is entered on the cycle of the last colShift. After PIPE_LAT
        // cycles, done lines up with the last out_valid.
        if (drain_cnt_q == DR_LAST) begin
          drain_cnt_d = '0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      data_q      <= '0;
      row_shift_q <= 1'b0;
      col_shift_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      img_rows_q  <= '0;
      rows_in_q   <= '0;
      load_cnt_q  <= '0;
      col_cnt_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      row_shift_q <= row_shift_d;
      col_shift_q <= col_shift_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      img_rows_q  <= img_rows_d;
      rows_in_q   <= rows_in_d;
      load_cnt_q  <= load_cnt_d;
      col_cnt_q   <= col_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // out_valid delay line. Reset empties it, so an aborted frame leaves
  // nothing behind in it.
  for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pipe_q[gi] <= 1'b0;
        else         pipe_q[gi] <= col_shift_q;
      end
    end else begin : g_tail
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) pipe_q[gi] <= 1'b0;
        else         pipe_q[gi] <= pipe_q[gi-1];
      end
    end
  end

  assign data_o      = data_q;
  assign rowShift_o  = row_shift_q;
  assign colShift_o  = col_shift_q;
  assign out_valid_o = pipe_q[PIPE_LAT-1];
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_conveng_feeder.sv
// Directed testbench for conveng_feeder with the default parameters
// (ROWS=16, COLS=18, NPIX=22, PIX_W=8, TAG_W=4, PIPE_LAT=4, H_W=12).
module tb_conveng_feeder;

  localparam int DW = 22*8 + 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [11:0]   img_rows_i = '0;
  logic [175:0]  in_data_i = '0;
  logic [3:0]    in_tag_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] data_o;
  logic          rowShift_o, colShift_o, out_valid_o, busy_o, done_o;

  conveng_feeder dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .img_rows_i(img_rows_i),
    .in_data_i(in_data_i), .in_tag_i(in_tag_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .data_o(data_o), .rowShift_o(rowShift_o),
    .colShift_o(colShift_o), .out_valid_o(out_valid_o), .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Event monitor, sampled on the falling edge (inputs change at posedge+1).
  logic clr = 1'b1;
  int cyc = 0;
  int n_row, n_col, n_ov, n_done, n_overlap, n_rs_bad, n_busy_bad, n_busy;
  int first_row, last_row, first_col, last_col, first_ov, last_ov, done_cyc;
  logic [DW-1:0] last_data;
  logic acc_prev, busy_prev;

  always @(negedge clk_i) begin
    cyc <= cyc + 1;
    if (clr) begin
      n_row <= 0; n_col <= 0; n_ov <= 0; n_done <= 0; n_overlap <= 0;
      n_rs_bad <= 0; n_busy_bad <= 0; n_busy <= 0;
      first_row <= -1; last_row <= -1; first_col <= -1; last_col <= -1;
      first_ov <= -1; last_ov <= -1; done_cyc <= -1;
      last_data <= '0; acc_prev <= 1'b0; busy_prev <= 1'b0;
    end else begin
      if (rst_ni && (rowShift_o !== acc_prev)) n_rs_bad <= n_rs_bad + 1;
      acc_prev  <= in_valid_i && in_ready_o && rst_ni;
      busy_prev <= busy_o;
      if (busy_o) n_busy <= n_busy + 1;
      if (rowShift_o) begin
        n_row <= n_row + 1; last_row <= cyc; last_data <= data_o;
        if (first_row < 0) first_row <= cyc;
      end
      if (colShift_o) begin
        n_col <= n_col + 1; last_col <= cyc;
        if (first_col < 0) first_col <= cyc;
      end
      if (out_valid_o) begin
        n_ov <= n_ov + 1; last_ov <= cyc;
        if (first_ov < 0) first_ov <= cyc;
      end
      if (rowShift_o && colShift_o) n_overlap <= n_overlap + 1;
      if (done_o) begin
        n_done <= n_done + 1; done_cyc <= cyc;
        if (busy_o || !busy_prev) n_busy_bad <= n_busy_bad + 1;
      end
    end
  end

  function automatic logic [175:0] slice(input int k, input logic [7:0] extra);
    logic [7:0] b;
    b = (k < 16) ? k[7:0] : extra;
    return {22{b}};
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  // Runs one frame and feeds slice k with bytes k (k<16) or `extra` after that.
  task automatic run_frame(input int rows, input logic [7:0] extra, input bit rand_v,
                           input int mid_start_at, output bit to);
    int k; int c; bit acc; bit seen;
    k = 0; c = 0; seen = 1'b0;
    in_tag_i = 4'hF; in_data_i = slice(0, extra); in_valid_i = 1'b1;
    img_rows_i = rows[11:0]; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    while (!seen && c < 3000) begin
      @(negedge clk_i);
      acc = in_valid_i && in_ready_o;
      seen = done_o;
      tick();
      c++;
      if (acc) k++;
      in_data_i = slice(k, extra);
      in_valid_i = rand_v ? ($urandom_range(0, 1) == 1) : 1'b1;
      start_i = (c == mid_start_at);
      if (c == mid_start_at) img_rows_i = 12'd20;
    end
    in_valid_i = 1'b0;
    start_i = 1'b0;
    to = !seen;
  endtask

  task automatic test_reset();
    logic [DW+5:0] outs;
    repeat (3) tick();
    outs = {data_o, rowShift_o, colShift_o, out_valid_o, busy_o, done_o, in_ready_o};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_held: got %h want 0", outs); end
    rst_ni = 1'b1;
    clear_mon();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      outs = {data_o, rowShift_o, colShift_o, out_valid_o, busy_o, done_o, in_ready_o};
      n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL reset_idle[%0d]: got %h want 0", i, outs); end
    end
    tick();
    $display("test_reset: idle after reset checked");
  endtask

  task automatic test_single_sweep();
    bit to;
    clear_mon();
    run_frame(16, 8'h55, 1'b0, -1, to);
    tick();
    n_cmp++; if (to) begin n_bad++; $display("FAIL t1_timeout: got no done want done"); end
    n_cmp++; if (n_row != 16) begin n_bad++; $display("FAIL t1_rows: got %0d want 16", n_row); end
    n_cmp++; if (last_row - first_row != 15) begin n_bad++; $display("FAIL t1_row_span: got %0d want 15", last_row - first_row); end
    n_cmp++; if (last_data !== {{22{8'h0F}}, 4'hF}) begin n_bad++; $display("FAIL t1_last_data: got %h want 0f..0f_f", last_data); end
    n_cmp++; if (n_col != 18) begin n_bad++; $display("FAIL t1_cols: got %0d want 18", n_col); end
    n_cmp++; if (first_col != last_row + 1 || last_col - first_col != 17) begin n_bad++; $display("FAIL t1_col_timing: got first %0d last %0d want %0d..%0d", first_col, last_col, last_row + 1, last_row + 18); end
    n_cmp++; if (n_ov != 18 || first_ov != first_col + 4 || last_ov != last_col + 4) begin n_bad++; $display("FAIL t1_out_valid: got n %0d first %0d want n 18 first %0d", n_ov, first_ov, first_col + 4); end
    n_cmp++; if (n_done != 1 || done_cyc != last_col + 4) begin n_bad++; $display("FAIL t1_done: got n %0d at %0d want 1 at %0d", n_done, done_cyc, last_col + 4); end
    n_cmp++; if (n_busy_bad != 0 || busy_o !== 1'b0) begin n_bad++; $display("FAIL t1_busy_fall: got bad %0d busy %b want 0 0", n_busy_bad, busy_o); end
    n_cmp++; if (data_o !== {{22{8'h0F}}, 4'hF}) begin n_bad++; $display("FAIL t1_data_hold: got %h want 0f..0f_f", data_o); end
    $display("test_single_sweep: rows %0d cols %0d ov %0d done %0d", n_row, n_col, n_ov, n_done);
  endtask

  task automatic test_advance();
    bit to;
    clear_mon();
    run_frame(17, 8'hEA, 1'b0, -1, to);
    tick();
    n_cmp++; if (to) begin n_bad++; $display("FAIL t2_timeout: got no done want done"); end
    n_cmp++; if (n_row != 17 || n_col != 36 || n_ov != 36 || n_done != 1) begin n_bad++; $display("FAIL t2_totals: got %0d/%0d/%0d/%0d want 17/36/36/1", n_row, n_col, n_ov, n_done); end
    n_cmp++; if (last_data !== {{22{8'hEA}}, 4'hF}) begin n_bad++; $display("FAIL t2_adv_data: got %h want ea..ea_f", last_data); end
    n_cmp++; if (last_row != first_col + 18 || last_col != first_col + 36) begin n_bad++; $display("FAIL t2_adv_timing: got row %0d lastcol %0d want %0d %0d", last_row, last_col, first_col + 18, first_col + 36); end
    n_cmp++; if (done_cyc != last_col + 4 || n_busy_bad != 0) begin n_bad++; $display("FAIL t2_done: got at %0d bad %0d want at %0d bad 0", done_cyc, n_busy_bad, last_col + 4); end
    $display("test_advance: rows %0d cols %0d ov %0d done %0d", n_row, n_col, n_ov, n_done);
  endtask

  task automatic test_stall();
    bit to;
    clear_mon();
    run_frame(18, 8'h3C, 1'b1, -1, to);
    tick();
    n_cmp++; if (to) begin n_bad++; $display("FAIL t3_timeout: got no done want done"); end
    n_cmp++; if (n_row != 18 || n_col != 54 || n_ov != 54 || n_done != 1) begin n_bad++; $display("FAIL t3_totals: got %0d/%0d/%0d/%0d want 18/54/54/1", n_row, n_col, n_ov, n_done); end
    n_cmp++; if (n_rs_bad != 0) begin n_bad++; $display("FAIL t3_row_accept: got %0d bad want 0", n_rs_bad); end
    n_cmp++; if (n_overlap != 0) begin n_bad++; $display("FAIL t3_overlap: got %0d want 0", n_overlap); end
    $display("test_stall: rows %0d cols %0d ov %0d done %0d", n_row, n_col, n_ov, n_done);
  endtask

  task automatic test_ignored_start();
    bit to;
    clear_mon();
    img_rows_i = 12'd15; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    n_cmp++; if (n_busy != 0 || n_done != 0 || n_row != 0) begin n_bad++; $display("FAIL t4_short_start: got busy %0d done %0d rows %0d want 0 0 0", n_busy, n_done, n_row); end
    clear_mon();
    run_frame(16, 8'h77, 1'b0, 20, to);
    tick();
    n_cmp++; if (to) begin n_bad++; $display("FAIL t4_timeout: got no done want done"); end
    n_cmp++; if (n_row != 16 || n_col != 18 || n_ov != 18 || n_done != 1) begin n_bad++; $display("FAIL t4_mid_start: got %0d/%0d/%0d/%0d want 16/18/18/1", n_row, n_col, n_ov, n_done); end
    repeat (10) tick();
    n_cmp++; if (busy_o !== 1'b0 || n_done != 1) begin n_bad++; $display("FAIL t4_no_restart: got busy %b done %0d want 0 1", busy_o, n_done); end
    $display("test_ignored_start: rows %0d cols %0d done %0d", n_row, n_col, n_done);
  endtask

  task automatic test_reset_abort();
    int ncol; int c; bit to;
    logic [DW+5:0] outs;
    clear_mon();
    in_tag_i = 4'hF; in_data_i = slice(0, 8'h00); in_valid_i = 1'b1;
    img_rows_i = 12'd16; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    ncol = 0; c = 0;
    while (ncol < 5 && c < 200) begin
      @(negedge clk_i);
      if (colShift_o) ncol++;
      c++;
    end
    n_cmp++; if (ncol != 5) begin n_bad++; $display("FAIL t5_reach_col5: got %0d want 5", ncol); end
    #1 rst_ni = 1'b0;
    #1;
    outs = {data_o, rowShift_o, colShift_o, out_valid_o, busy_o, done_o, in_ready_o};
    n_cmp++; if (outs !== '0) begin n_bad++; $display("FAIL t5_async_clear: got %h want 0", outs); end
    in_valid_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b1;
    clear_mon();
    repeat (20) tick();
    n_cmp++; if (n_ov != 0 || n_col != 0 || n_done != 0 || n_busy != 0) begin n_bad++; $display("FAIL t5_no_residue: got ov %0d col %0d done %0d busy %0d want 0", n_ov, n_col, n_done, n_busy); end
    clear_mon();
    run_frame(16, 8'h11, 1'b0, -1, to);
    tick();
    n_cmp++; if (to || n_row != 16 || n_col != 18 || n_ov != 18 || n_done != 1) begin n_bad++; $display("FAIL t5_restart: got to %0d %0d/%0d/%0d/%0d want 0 16/18/18/1", to, n_row, n_col, n_ov, n_done); end
    $display("test_reset_abort: restart rows %0d cols %0d done %0d", n_row, n_col, n_done);
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_advance();
    test_stall();
    test_ignored_start();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
